// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq : iterative radix-2 restoring divider for MIPS div / divu.
//
// The divider produces one quotient bit per cycle. While a division is being
// accepted or is running, it holds the pipeline through stallreq. When the
// division completes, it presents a sign-corrected quotient and remainder.
// ready is high for exactly one cycle, and EX/MEM uses that cycle to write
// HI/LO.
//
// Ports
//   clk         in   1      clock, rising edge
//   rst         in   1      asynchronous reset, active low
//   start       in   1      division request, only honoured in IDLE
//   signed_div  in   1      1 = two's complement (div), 0 = unsigned (divu)
//   dividend    in   WIDTH  numerator, sampled with an accepted start
//   divisor     in   WIDTH  denominator, sampled with an accepted start
//   annul       in   1      cancel the current operation, returns to IDLE
//   stallreq    out  1      combinational stall request toward CTRL
//   ready       out  1      registered, one-cycle result-valid strobe
//   quotient    out  WIDTH  registered quotient (LO)
//   remainder   out  WIDTH  registered remainder (HI)
// -----------------------------------------------------------------------------
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             annul,
    output logic             stallreq,
    output logic             ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Two's complement negation. The negation is modular, so the most
    // negative value maps onto itself.
    function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] v);
        return (~v) + WIDTH'(1);
    endfunction

    // Negate the value only when the flag is set.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
        return neg ? neg2c(v) : v;
    endfunction

    state_t             state_r;
    state_t             state_nx_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   rem_r;      // partial remainder (always below divisor)
    logic [WIDTH-1:0]   dvd_r;      // working dividend, shifted out as quotient shifts in
    logic [WIDTH-1:0]   dsr_r;      // divisor magnitude
    logic               qneg_r;
    logic               rneg_r;
    logic               ready_r;
    logic [WIDTH-1:0]   quo_out_r;
    logic [WIDTH-1:0]   rem_out_r;

    logic               accept_s;
    logic               div_zero_s;
    logic               dvd_sign_s;
    logic               dsr_sign_s;
    logic [WIDTH-1:0]   dvd_mag_s;
    logic [WIDTH-1:0]   dsr_mag_s;
    logic [WIDTH:0]     shifted_s;
    logic [WIDTH:0]     diff_s;
    logic               qbit_s;
    logic [WIDTH-1:0]   rem_step_s;
    logic [WIDTH-1:0]   quo_step_s;

    // Request qualification and operand conditioning for an accepted start.
    always_comb begin
        accept_s   = (state_r == ST_IDLE) && start && !annul;
        div_zero_s = (divisor == '0);
        dvd_sign_s = signed_div && dividend[WIDTH-1];
        dsr_sign_s = signed_div && divisor[WIDTH-1];
        dvd_mag_s  = cond_neg(dividend, dvd_sign_s);
        dsr_mag_s  = cond_neg(divisor, dsr_sign_s);
    end

    // One restoring step: shift the pair left, trial-subtract, keep or restore.
    // The stored remainder is always below the divisor, so after the step it
    // fits in WIDTH bits. Only the trial value needs the extra sign bit.
    always_comb begin
        shifted_s  = {rem_r, dvd_r[WIDTH-1]};
        diff_s     = shifted_s - {1'b0, dsr_r};
        qbit_s     = ~diff_s[WIDTH];
        rem_step_s = '0;
        if (qbit_s) begin
            rem_step_s = diff_s[WIDTH-1:0];
        end else begin
            rem_step_s = shifted_s[WIDTH-1:0];
        end
        quo_step_s = {dvd_r[WIDTH-2:0], qbit_s};
    end

    // Next-state logic. annul overrides every other transition.
    always_comb begin
        state_nx_s = state_r;
        if (annul) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_nx_s = div_zero_s ? ST_DONE : ST_BUSY;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (cnt_r == CNT_LAST) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        state_nx_s = ST_BUSY;
                    end
                end
                ST_DONE: state_nx_s = ST_IDLE;
                default: state_nx_s = ST_IDLE;
            endcase
        end
    end

    // Stall covers the request cycle, so the div instruction stays in EX.
    always_comb begin
        stallreq = 1'b0;
        if (accept_s || (state_r == ST_BUSY)) begin
            stallreq = 1'b1;
        end else begin
            stallreq = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Datapath: operand latch, iteration, and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r     <= '0;
            rem_r     <= '0;
            dvd_r     <= '0;
            dsr_r     <= '0;
            qneg_r    <= 1'b0;
            rneg_r    <= 1'b0;
            ready_r   <= 1'b0;
            quo_out_r <= '0;
            rem_out_r <= '0;
        end else begin
            // Only a non-annulled transition into DONE can raise ready.
            ready_r <= (state_nx_s == ST_DONE);
            if (annul) begin
                cnt_r <= cnt_r;
            end else if (accept_s) begin
                cnt_r  <= '0;
                rem_r  <= '0;
                dvd_r  <= dvd_mag_s;
                dsr_r  <= dsr_mag_s;
                qneg_r <= dvd_sign_s ^ dsr_sign_s;
                rneg_r <= dvd_sign_s;
                if (div_zero_s) begin
                    quo_out_r <= '1;
                    rem_out_r <= dividend;
                end else begin
                    quo_out_r <= quo_out_r;
                end
            end else if (state_r == ST_BUSY) begin
                cnt_r <= cnt_r + CNT_W'(1);
                rem_r <= rem_step_s;
                dvd_r <= quo_step_s;
                if (cnt_r == CNT_LAST) begin
                    quo_out_r <= cond_neg(quo_step_s, qneg_r);
                    rem_out_r <= cond_neg(rem_step_s, rneg_r);
                end else begin
                    quo_out_r <= quo_out_r;
                end
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign ready     = ready_r;
    assign quotient  = quo_out_r;
    assign remainder = rem_out_r;

endmodule

// File: tb/tb_div_seq.sv
// -----------------------------------------------------------------------------
// tb_div_seq : self-checking bench for div_seq.
// A plain-arithmetic reference model supplies the expected results. Each
// division is observed cycle by cycle for stall, ready and result timing.
// -----------------------------------------------------------------------------
module tb_div_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        annul;
    logic        stallreq;
    logic        ready;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int          checks_r;
    int          errors_r;
    logic [31:0] last_q_r;
    logic [31:0] last_r_r;

    div_seq #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .dividend   (dividend),
        .divisor    (divisor),
        .annul      (annul),
        .stallreq   (stallreq),
        .ready      (ready),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it if it does not match.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r++;
        if (got !== exp) begin
            errors_r++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: MIPS div/divu semantics, truncating division, remainder takes dividend sign.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                  output logic [31:0] q, output logic [31:0] r);
        int     ia;
        int     ib;
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn) begin
            ia = a;
            ib = b;
            sa = ia;
            sb = ib;
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Issue one division and watch each cycle until one past the expected ready.
    // If annul_cyc > 0, annul is raised in that cycle and the result must never appear.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           input int annul_cyc);
        logic [31:0] eq;
        logic [31:0] er;
        int          lat;
        bit          killed;
        bit          show;
        model(a, b, sgn, eq, er);
        lat    = (b == 32'd0) ? 1 : 33;
        killed = 1'b0;
        @(negedge clk);
        start      = 1'b1;
        signed_div = sgn;
        dividend   = a;
        divisor    = b;
        annul      = 1'b0;
        #1;
        check_val("req_stall", 32'(stallreq), 32'd1);
        check_val("req_ready", 32'(ready), 32'd0);
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            killed     = (annul_cyc > 0) && (c > annul_cyc);
            start      = (killed || c == lat + 1) ? 1'b0 : 1'($urandom_range(0, 1));
            dividend   = $urandom;
            divisor    = $urandom;
            signed_div = 1'($urandom_range(0, 1));
            annul      = (c == annul_cyc);
            #1;
            show = !killed && (annul_cyc != lat - 1 || c < lat) && (c >= lat);
            if (annul_cyc == lat - 1) begin
                show = 1'b0;
            end
            check_val($sformatf("stall_c%0d", c), 32'(stallreq),
                      32'(!killed && c < lat));
            check_val($sformatf("ready_c%0d", c), 32'(ready),
                      32'(!killed && annul_cyc != lat - 1 && c == lat));
            check_val($sformatf("quot_c%0d", c), quotient, show ? eq : last_q_r);
            check_val($sformatf("rem_c%0d", c), remainder, show ? er : last_r_r);
        end
        if (annul_cyc <= 0) begin
            last_q_r = eq;
            last_r_r = er;
        end
        start = 1'b0;
    endtask

    logic [31:0] ra;
    logic [31:0] rb;

    initial begin
        checks_r   = 0;
        errors_r   = 0;
        last_q_r   = 32'd0;
        last_r_r   = 32'd0;
        rst        = 1'b0;
        start      = 1'b0;
        signed_div = 1'b0;
        dividend   = 32'd0;
        divisor    = 32'd0;
        annul      = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_stall", 32'(stallreq), 32'd0);
        check_val("rst_ready", 32'(ready), 32'd0);
        check_val("rst_quot", quotient, 32'd0);
        check_val("rst_rem", remainder, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // A start together with annul is not a request.
        @(negedge clk);
        start    = 1'b1;
        annul    = 1'b1;
        dividend = 32'd10;
        divisor  = 32'd3;
        #1;
        check_val("annul_req_stall", 32'(stallreq), 32'd0);
        @(negedge clk);
        start = 1'b0;
        annul = 1'b0;
        #1;
        check_val("annul_req_idle", 32'(stallreq), 32'd0);
        check_val("annul_req_ready", 32'(ready), 32'd0);

        run_div(32'd100, 32'd7, 1'b0, -1);
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, -1);
        run_div(32'hFFFF_FFF9, 32'd2, 1'b0, -1);
        run_div(32'h0000_1234, 32'd0, 1'b0, -1);
        run_div(32'h8000_0005, 32'd0, 1'b1, -1);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1);
        run_div(32'd100, 32'd7, 1'b0, 10);
        run_div(32'd9, 32'd3, 1'b0, -1);
        run_div(32'd77, 32'd5, 1'b0, 32);
        run_div(32'hFFFF_FF9C, 32'd7, 1'b1, -1);

        // Reset in the middle of a running division.
        @(negedge clk);
        start      = 1'b1;
        signed_div = 1'b0;
        dividend   = 32'd123456;
        divisor    = 32'd789;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b0;
        #1;
        check_val("midrst_stall", 32'(stallreq), 32'd0);
        check_val("midrst_ready", 32'(ready), 32'd0);
        check_val("midrst_quot", quotient, 32'd0);
        check_val("midrst_rem", remainder, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        last_q_r = 32'd0;
        last_r_r = 32'd0;
        #1;
        check_val("postrst_stall", 32'(stallreq), 32'd0);
        check_val("postrst_ready", 32'(ready), 32'd0);
        run_div(32'd50, 32'd5, 1'b0, -1);

        // Random operands, biased toward zero and small divisors.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                3:       rb = 32'($urandom_range(1, 1000)) | 32'h8000_0000;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) begin
                ra = 32'h8000_0000;
            end
            run_div(ra, rb, 1'($urandom_range(0, 1)), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule

// File: doc/div_seq.md
# div_seq

Iterative 32/32 radix-2 divider with its own sequencing FSM, for MIPS `div`/`divu` in the EX stage. EX pulses `start` with operands. The block runs one quotient bit per cycle and raises `stallreq` toward CTRL to freeze the pipeline while busy. It then presents quotient and remainder for one `ready` cycle, which EX/MEM uses to write HI/LO.

## Interface
- `WIDTH`, 32, operand/result width; iteration count equals `WIDTH`.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a division; sampled only in IDLE.
- `signed_div`  in  1  1 = `div` (two's complement), 0 = `divu`; sampled with `start`.
- `dividend`  in  WIDTH  numerator; sampled with `start`.
- `divisor`  in  WIDTH  denominator; sampled with `start`.
- `annul`  in  1  cancel; highest priority after reset.
- `stallreq`  out  1  pipeline stall request to CTRL.
- `ready`  out  1  result valid, exactly one cycle per completed division.
- `quotient`  out  WIDTH  registered quotient (HI/LO lo).
- `remainder`  out  WIDTH  registered remainder (HI/LO hi).

## Operation
- States:
  - IDLE
  - BUSY: 5-bit counter `cnt` (log2 WIDTH bits).
  - DONE
- Reset (`rst`=0, async):
  - state = IDLE, `cnt` = 0.
  - `quotient` = 0, `remainder` = 0, `ready` = 0, `stallreq` = 0.
- IDLE + `start`=1 + `annul`=0:
  - Latch |dividend| and |divisor|. Magnitudes are taken only when `signed_div`=1; otherwise the raw values are used.
  - Latch sign flags: `qneg` = sign(dividend) XOR sign(divisor); `rneg` = sign(dividend). Both are forced to 0 when unsigned.
  - If divisor = 0: go to DONE with `quotient` = all ones and `remainder` = dividend (raw).
  - Otherwise go to BUSY with `cnt` = 0 and the partial remainder cleared.
- BUSY step (one per cycle), restoring algorithm:
  - Shift the {partial remainder, working dividend} pair left by 1.
  - Trial-subtract the divisor magnitude from the upper WIDTH+1 bits.
  - If the result is non-negative, keep the difference and shift in quotient bit 1; otherwise keep the shifted value and shift in 0.
- When `cnt` = WIDTH-1, the step's result is sign-corrected and loaded into the output registers. The state then goes to DONE.
  - `quotient` = `qneg` ? −q : q.
  - `remainder` = `rneg` ? −r : r.
- DONE:
  - `ready` = 1 for this cycle only.
  - The state unconditionally returns to IDLE.
  - A `start` in DONE is ignored; EX must re-present it in IDLE.
- `annul`=1 in any state: next state is IDLE, the output registers are unchanged, and `ready` stays 0 (including an `annul` during DONE's predecessor edge).
- `start` outside IDLE is ignored; operands are not re-sampled.
- `quotient`/`remainder` hold their last value until the next completion or reset.
- Overflow case 0x80000000 / 0xFFFFFFFF signed: `quotient` = 0x80000000, `remainder` = 0. This falls out of modular negation; no trap is raised.
- Arithmetic widths:
  - Partial remainder is WIDTH+1 bits; the difference sign is its MSB.
  - Negation is two's complement modulo 2^WIDTH.

## Timing
- `stallreq` is combinational:
  - 1 when (IDLE & `start` & ~`annul`) or BUSY.
  - 0 in DONE and in IDLE without a request.
  - The request cycle itself stalls so the `div` stays in EX.
- Normal latency:
  - `start` in cycle 0.
  - BUSY in cycles 1..WIDTH (32 cycles).
  - DONE/`ready` in cycle WIDTH+1 = 33.
  - `stallreq` is high in cycles 0..32 (33 cycles) and low in cycle 33, so the instruction advances with the result.
- Divide-by-zero latency: `start` in cycle 0, `ready` in cycle 1, `stallreq` high in cycle 0 only.
- Back-to-back: the earliest next accepted `start` is the IDLE cycle after DONE (cycle 34).
- Reset asserted mid-BUSY: all outputs go to their reset values immediately. No `ready` is produced, and the block resumes in IDLE after deassertion.

## Test plan
- Unsigned 100 / 7, start at cycle 0 -> `ready` only in cycle 33 with `quotient` = 14 and `remainder` = 2; `stallreq` high in cycles 0–32.
- Signed −7 / 2 (0xFFFFFFF9 / 2) -> `quotient` = 0xFFFFFFFD and `remainder` = 0xFFFFFFFF. Also unsigned 0xFFFFFFF9 / 2 -> `quotient` = 0x7FFFFFFC and `remainder` = 1.
- Divisor 0, dividend 0x1234 -> `ready` in cycle 1 with `quotient` = 0xFFFFFFFF and `remainder` = 0x1234; `stallreq` high only in cycle 0.
- Signed 0x80000000 / 0xFFFFFFFF -> `quotient` = 0x80000000 and `remainder` = 0 in cycle 33.
- Start 100/7, assert `annul` in cycle 10 -> IDLE in cycle 11, no `ready`, outputs keep their prior values. Then start 9/3 -> `quotient` = 3 and `remainder` = 0 exactly 33 cycles later.
- Start a division, pull `rst` low in cycle 15 -> all outputs are 0 immediately. After release, 50/5 -> `quotient` = 10 and `remainder` = 0 at the normal latency; a `start` pulsed during BUSY is ignored.
